am_demod_cordic: RTL and testbench

Parametrised AM envelope detector for the I/Q path after the CIC decimators. It accepts one decimated I/Q pair per input tick and computes the magnitude with an iterative (one micro-rotation per clock) CORDIC in vectoring mode. It then applies gain compensation and an optional DC-blocking high-pass, and emits one audio sample with an output tick. It supersedes the fixed-width demodulator with configurable width, iteration count, DC time constant and a runtime DC-block mode.

---
 rtl/am_pkg.sv | 32 +++
 rtl/cordic_mag_iter.sv | 51 +++++
 rtl/am_demod_cordic.sv | 139 +++++++++++++
 tb/tb_am_demod_cordic.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/am_pkg.sv
// Shared types, constants and helpers for the CORDIC AM envelope detector.
package am_pkg;

    localparam int unsigned CORDIC_GUARD   = 2;
    localparam int unsigned CORDIC_K       = 39797;
    localparam int unsigned CORDIC_K_SHIFT = 16;
    localparam int unsigned CORDIC_K_W     = 17;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ROT,
        SCALE,
        OUT
    } state_t;

    // Clamp a signed value into the range of a w-bit two's complement word.
    function automatic logic signed [63:0] sat_s(input logic signed [63:0] v,
                                                 input int unsigned w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/cordic_mag_iter.sv
// Iterative vectoring CORDIC: one micro-rotation per clock, x converges to gain*|v|.
module cordic_mag_iter #(
    parameter int unsigned W    = 18,
    parameter int unsigned ITER = 14
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic signed [W-1:0] x0,
    input  logic signed [W-1:0] y0,
    output logic                done_c,
    output logic signed [W-1:0] x
);

    localparam int unsigned KW = (ITER > 1) ? $clog2(ITER) : 1;

    logic signed [W-1:0] y;
    logic [KW-1:0]       k;
    logic                run;

    // Last rotation is in progress this cycle.
    assign done_c = run && (k == KW'(ITER - 1));

    // Load folded operands on start, then rotate towards y=0 until the last step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x   <= '0;
            y   <= '0;
            k   <= '0;
            run <= 1'b0;
        end else if (start) begin
            x   <= (x0 < 0) ? -x0 : x0;
            y   <= (y0 < 0) ? -y0 : y0;
            k   <= '0;
            run <= 1'b1;
        end else if (run) begin
            if (y >= 0) begin
                x <= x + (y >>> k);
                y <= y - (x >>> k);
            end else begin
                x <= x - (y >>> k);
                y <= y + (x >>> k);
            end
            k <= k + KW'(1);
            if (done_c) begin
                run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/am_demod_cordic.sv
// AM envelope detector: CORDIC magnitude, gain compensation, optional DC blocker.
module am_demod_cordic
    import am_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ITER      = 14,
    parameter int unsigned DC_SHIFT  = 10,
    parameter int unsigned GAIN_COMP = 1
) (
    input  logic                     CLK,
    input  logic                     RSTb,
    input  logic signed [DATA_W-1:0] i_in,
    input  logic signed [DATA_W-1:0] q_in,
    input  logic                     in_tick,
    input  logic                     dc_en,
    output logic signed [DATA_W-1:0] demod_out,
    output logic                     out_tick,
    output logic                     busy,
    output logic                     overrun
);

    localparam int unsigned W  = DATA_W + CORDIC_GUARD;
    localparam int unsigned PW = W + CORDIC_K_W;
    localparam int unsigned AW = DATA_W + DC_SHIFT + 1;

    state_t                   state;
    state_t                   state_d;
    logic                     start;
    logic                     done_c;
    logic signed [W-1:0]      cx;
    logic signed [DATA_W-1:0] i_cap;
    logic signed [DATA_W-1:0] q_cap;
    logic signed [DATA_W-1:0] mag;
    logic signed [AW-1:0]     acc;
    logic signed [PW-1:0]     prod;
    logic signed [PW-1:0]     scaled;
    logic signed [63:0]       mag_wide;
    logic signed [DATA_W-1:0] mag_c;
    logic signed [AW-1:0]     d_c;
    logic signed [DATA_W-1:0] d_sat;

    cordic_mag_iter #(
        .W    (W),
        .ITER (ITER)
    ) u_cordic (
        .clk    (CLK),
        .rst_n  (RSTb),
        .start  (start),
        .x0     (W'(i_cap)),
        .y0     (W'(q_cap)),
        .done_c (done_c),
        .x      (cx)
    );

    // State register.
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic; PREP kicks off the CORDIC.
    always_comb begin
        state_d = state;
        start   = 1'b0;
        case (state)
            IDLE:    if (in_tick) state_d = PREP;
            PREP: begin
                start   = 1'b1;
                state_d = ROT;
            end
            ROT:     if (done_c) state_d = SCALE;
            SCALE:   state_d = OUT;
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Gain compensation and clamp of the CORDIC result to the positive output range.
    always_comb begin
        prod = PW'(cx) * $signed(PW'(CORDIC_K));
        if (GAIN_COMP != 0) begin
            scaled = prod >>> CORDIC_K_SHIFT;
        end else begin
            scaled = PW'(cx);
        end
        mag_wide = sat_s(64'(scaled), DATA_W);
        if (mag_wide < 0) begin
            mag_wide = '0;
        end
        mag_c = DATA_W'(mag_wide);
    end

    // DC blocker: subtract the running mean tracked in acc.
    always_comb begin
        d_c   = AW'(mag) - (acc >>> DC_SHIFT);
        d_sat = DATA_W'(sat_s(64'(d_c), DATA_W));
    end

    // Capture, scaling, DC accumulator and registered status/outputs.
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            i_cap     <= '0;
            q_cap     <= '0;
            mag       <= '0;
            acc       <= '0;
            demod_out <= '0;
            out_tick  <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            out_tick <= 1'b0;
            busy     <= (state_d != IDLE);
            if (in_tick && busy) begin
                overrun <= 1'b1;
            end
            if (state == IDLE && in_tick) begin
                i_cap <= i_in;
                q_cap <= q_in;
            end
            if (state == SCALE) begin
                mag <= mag_c;
            end
            if (state == OUT) begin
                out_tick <= 1'b1;
                if (dc_en) begin
                    acc       <= acc + d_c;
                    demod_out <= d_sat;
                end else begin
                    acc       <= '0;
                    demod_out <= mag;
                end
            end
        end
    end

endmodule

// File: tb/tb_am_demod_cordic.sv
// Self-checking bench for am_demod_cordic against a real-valued magnitude model.
module tb_am_demod_cordic;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned ITER     = 14;
    localparam int unsigned DC_SHIFT = 6;
    localparam int          LAT      = ITER + 3;
    localparam int          MAXV     = 32767;

    logic                     CLK = 1'b0;
    logic                     RSTb;
    logic signed [DATA_W-1:0] i_in;
    logic signed [DATA_W-1:0] q_in;
    logic                     in_tick;
    logic                     dc_en;
    logic signed [DATA_W-1:0] demod_out;
    logic                     out_tick;
    logic                     busy;
    logic                     overrun;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    am_demod_cordic #(
        .DATA_W    (DATA_W),
        .ITER      (ITER),
        .DC_SHIFT  (DC_SHIFT),
        .GAIN_COMP (1)
    ) dut (
        .CLK       (CLK),
        .RSTb      (RSTb),
        .i_in      (i_in),
        .q_in      (q_in),
        .in_tick   (in_tick),
        .dc_en     (dc_en),
        .demod_out (demod_out),
        .out_tick  (out_tick),
        .busy      (busy),
        .overrun   (overrun)
    );

    // Ideal envelope: Euclidean magnitude, rounded, clamped to the output range.
    function automatic int ref_mag(input int i, input int q);
        real r;
        r = $sqrt(real'(i) * real'(i) + real'(q) * real'(q));
        if (r > real'(MAXV)) r = real'(MAXV);
        return $rtoi(r + 0.5);
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // One sample: tick, optionally change dc_en after the tick, wait for out_tick.
    task automatic run_sample(input int i, input int q, input logic dc_tick,
                              input logic dc_after, output int res, output int lat);
        @(negedge CLK);
        i_in    = DATA_W'(i);
        q_in    = DATA_W'(q);
        dc_en   = dc_tick;
        in_tick = 1'b1;
        @(posedge CLK);
        #1;
        in_tick = 1'b0;
        dc_en   = dc_after;
        lat     = -1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge CLK);
            #1;
            if (out_tick) begin
                lat = c;
                break;
            end
        end
        res = int'(demod_out);
    endtask

    task automatic test_reset();
        RSTb = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge CLK);
            i_in    = DATA_W'($urandom);
            q_in    = DATA_W'($urandom);
            in_tick = 1'($urandom);
            dc_en   = 1'($urandom);
            @(posedge CLK);
            #1;
            checks++;
            if (demod_out !== '0 || out_tick !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
                failures++;
                $display("FAIL reset_state out=%0d tick=%b busy=%b ovr=%b exp all 0",
                         demod_out, out_tick, busy, overrun);
            end
        end
        @(negedge CLK);
        in_tick = 1'b0;
        dc_en   = 1'b0;
        RSTb    = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge CLK);
            #1;
            checks++;
            if (busy !== 1'b0) begin
                failures++;
                $display("FAIL idle_busy got=%b exp=0", busy);
            end
        end
    endtask

    task automatic test_basic();
        int res, lat, held;
        int iv[2] = '{3000, -3000};
        int qv[2] = '{4000, -4000};
        for (int n = 0; n < 2; n++) begin
            run_sample(iv[n], qv[n], 1'b0, 1'b0, res, lat);
            checks++;
            if (lat != LAT) begin
                failures++;
                $display("FAIL basic_latency got=%0d exp=%0d", lat, LAT);
            end
            checks++;
            if (iabs(res - 5000) > 2) begin
                failures++;
                $display("FAIL basic_mag i=%0d q=%0d got=%0d exp=5000+-2", iv[n], qv[n], res);
            end
            @(posedge CLK);
            #1;
            checks++;
            if (out_tick !== 1'b0) begin
                failures++;
                $display("FAIL tick_width got=%b exp=0", out_tick);
            end
            held = res;
            repeat (6) @(posedge CLK);
            #1;
            checks++;
            if (int'(demod_out) != held) begin
                failures++;
                $display("FAIL hold got=%0d exp=%0d", demod_out, held);
            end
        end
    endtask

    task automatic test_corners();
        int res, lat, expv;
        int iv[4] = '{-32768, 0, 32767, -32768};
        int qv[4] = '{-32768, 0, 0, 0};
        for (int n = 0; n < 4; n++) begin
            run_sample(iv[n], qv[n], 1'b0, 1'b0, res, lat);
            expv = ref_mag(iv[n], qv[n]);
            checks++;
            if ((n < 2 && res != expv) || iabs(res - expv) > 2 || res < 0) begin
                failures++;
                $display("FAIL corner i=%0d q=%0d got=%0d exp=%0d lat=%0d", iv[n], qv[n], res, expv, lat);
            end
        end
    endtask

    task automatic test_random();
        int res, lat, i, q, expv;
        for (int n = 0; n < 24; n++) begin
            i = int'($urandom_range(65535)) - 32768;
            q = int'($urandom_range(65535)) - 32768;
            if (n < 8) begin
                i = i / 64;
                q = q / 64;
            end
            run_sample(i, q, 1'b0, 1'b0, res, lat);
            expv = ref_mag(i, q);
            checks++;
            if (iabs(res - expv) > 4 || lat != LAT) begin
                failures++;
                $display("FAIL random i=%0d q=%0d got=%0d exp=%0d lat=%0d", i, q, res, expv, lat);
            end
        end
    endtask

    task automatic test_back_to_back();
        int res, lat;
        run_sample(600, 800, 1'b0, 1'b0, res, lat);
        run_sample(-1200, 500, 1'b0, 1'b0, res, lat);
        checks++;
        if (lat != LAT || iabs(res - 1300) > 2) begin
            failures++;
            $display("FAIL back_to_back got=%0d lat=%0d exp=1300 lat=%0d", res, lat, LAT);
        end
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL b2b_overrun got=%b exp=0", overrun);
        end
    endtask

    task automatic test_dc_block();
        int res, lat, prev, bad_lat;
        run_sample(10000, 0, 1'b1, 1'b1, res, lat);
        checks++;
        if (iabs(res - 10000) > 2 || lat != LAT) begin
            failures++;
            $display("FAIL dc_first got=%0d lat=%0d exp=10000+-2", res, lat);
        end
        prev    = res;
        bad_lat = 0;
        for (int n = 1; n < 1024; n++) begin
            run_sample(10000, 0, 1'b1, 1'b1, res, lat);
            if (lat != LAT) bad_lat++;
            checks++;
            if (res > prev || res < 0) begin
                failures++;
                $display("FAIL dc_decay n=%0d got=%0d prev=%0d", n, res, prev);
            end
            prev = res;
        end
        checks++;
        if (bad_lat != 0) begin
            failures++;
            $display("FAIL dc_latency bad=%0d exp=0", bad_lat);
        end
        checks++;
        if (iabs(res) > 1) begin
            failures++;
            $display("FAIL dc_settled got=%0d exp=|x|<=1", res);
        end
        run_sample(10000, 0, 1'b1, 1'b0, res, lat);
        checks++;
        if (iabs(res - 10000) > 2) begin
            failures++;
            $display("FAIL dc_bypass got=%0d exp=10000+-2", res);
        end
        run_sample(10000, 0, 1'b1, 1'b1, res, lat);
        checks++;
        if (iabs(res - 10000) > 2) begin
            failures++;
            $display("FAIL dc_cleared got=%0d exp=10000+-2", res);
        end
        dc_en = 1'b0;
    endtask

    task automatic test_overrun();
        int ticks, res, lat;
        @(negedge CLK);
        i_in    = DATA_W'(3000);
        q_in    = DATA_W'(4000);
        in_tick = 1'b1;
        @(posedge CLK);
        #1;
        in_tick = 1'b0;
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        i_in    = DATA_W'(100);
        q_in    = DATA_W'(0);
        in_tick = 1'b1;
        ticks   = 0;
        @(posedge CLK);
        #1;
        in_tick = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge CLK);
            #1;
            if (out_tick) begin
                ticks++;
                res = int'(demod_out);
            end
        end
        checks++;
        if (ticks != 1) begin
            failures++;
            $display("FAIL overrun_ticks got=%0d exp=1", ticks);
        end
        checks++;
        if (iabs(res - 5000) > 2) begin
            failures++;
            $display("FAIL overrun_value got=%0d exp=5000+-2", res);
        end
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_flag got=%b exp=1", overrun);
        end
        run_sample(-500, 1200, 1'b0, 1'b0, res, lat);
        checks++;
        if (overrun !== 1'b1 || iabs(res - 1300) > 2) begin
            failures++;
            $display("FAIL overrun_sticky ovr=%b val=%0d exp ovr=1 val=1300", overrun, res);
        end
    endtask

    task automatic test_reset_mid();
        int ticks, res, lat;
        @(negedge CLK);
        i_in    = DATA_W'(3000);
        q_in    = DATA_W'(4000);
        in_tick = 1'b1;
        @(posedge CLK);
        #1;
        in_tick = 1'b0;
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        RSTb = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || overrun !== 1'b0 || demod_out !== '0) begin
            failures++;
            $display("FAIL mid_reset busy=%b ovr=%b out=%0d exp 0", busy, overrun, demod_out);
        end
        @(negedge CLK);
        RSTb  = 1'b1;
        ticks = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge CLK);
            #1;
            if (out_tick) ticks++;
        end
        checks++;
        if (ticks != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_abort ticks=%0d busy=%b exp 0 0", ticks, busy);
        end
        run_sample(6000, -8000, 1'b0, 1'b0, res, lat);
        checks++;
        if (iabs(res - 10000) > 2 || lat != LAT) begin
            failures++;
            $display("FAIL post_reset got=%0d lat=%0d exp=10000 lat=%0d", res, lat, LAT);
        end
    endtask

    initial begin
        RSTb    = 1'b0;
        i_in    = '0;
        q_in    = '0;
        in_tick = 1'b0;
        dc_en   = 1'b0;
        test_reset();
        test_basic();
        test_corners();
        test_random();
        test_back_to_back();
        test_dc_block();
        test_overrun();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
